cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
- Direct-mapped, write-through cache controller placed between the two-thread stack processor's fetch/load/store front end and slowmem.
- Serves read hits in one cycle and forwards misses and all writes to slowmem using its strobe/rnotw/mfc protocol.
- Keeps at most one memory operation in flight, so the processor sees one simple request/done interface for instruction fetch and data access.

Parameters:
- ADDR_W, 16, address width (word addressed)
- DATA_W, 16, data word width
- LINES, 8, number of one-word lines (power of two); IDX_W = log2(LINES) = 3, TAG_W = ADDR_W - IDX_W = 13

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- cpu_req  in  1  single-cycle request pulse; accepted only while cpu_busy=0
- cpu_rnotw  in  1  1=read, 0=write; sampled with cpu_req
- cpu_addr  in  ADDR_W  request address
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read result; valid while cpu_done=1
- cpu_done  out  1  one-cycle completion pulse
- cpu_busy  out  1  1 whenever FSM is not IDLE
- mem_strobe  out  1  slowmem strobe
- mem_rnotw  out  1  slowmem read/not-write
- mem_addr  out  ADDR_W  slowmem address
- mem_wdata  out  DATA_W  slowmem write data
- mem_mfc  in  1  slowmem memory-function-complete, one-cycle pulse
- mem_rdata  in  DATA_W  slowmem read data; valid with mem_mfc

Behaviour:
- Address split: index = addr[IDX_W-1:0]; tag = addr[ADDR_W-1:IDX_W]. Hit means valid[index] is set and tag[index] equals the request tag.
- Reset (async): all valid bits cleared and FSM set to IDLE. cpu_done, cpu_busy, mem_strobe and cpu_rdata are 0. mem_rnotw=1; mem_addr and mem_wdata are 0. Tag/data arrays need no reset.
- The FSM has five states: IDLE, RESP, MREQ, MWAIT, WREQ.
- IDLE: on cpu_req, capture rnotw, addr and wdata.
  - Read hit -> RESP, with cpu_rdata loaded from the line.
  - Read miss -> MREQ.
  - Write -> WREQ; writes are forwarded whether they hit or miss.
- MREQ (one cycle): mem_strobe=1, mem_rnotw=1, mem_addr=captured addr -> MWAIT.
- MWAIT: mem_strobe=0. Wait for mem_mfc with no cycle limit.
  - On mem_mfc: write data=mem_rdata, tag and valid=1 into the line; cpu_rdata=mem_rdata -> RESP.
- WREQ (one cycle): mem_strobe=1, mem_rnotw=0, mem_addr and mem_wdata from the captured request.
  - Write hit: the line data is updated in the same cycle.
  - Write miss: no allocate; the line is untouched.
  - Next state is RESP.
- RESP: cpu_done=1 for exactly one cycle -> IDLE. cpu_busy stays 1 here, so a new request can be issued only from the following cycle.
- Latencies: read hit = done in cycle N+1 after a request in cycle N. Write = done at N+2. Read miss = done 2 cycles after mem_mfc's edge plus the slowmem delay (MEMDELAY=4), i.e. about N+7.
- cpu_req while cpu_busy=1 is ignored; it is not queued and has no side effects.
- mem_strobe is never high for two consecutive cycles, and never high while in MWAIT.
- mem_mfc arriving outside MWAIT is ignored.
- Reset mid-miss returns to IDLE with all lines invalid. The slowmem pulse that may follow is ignored because of the rule above.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined: adds outputs hit_count and miss_count, each 16 bits, reset to 0.
  - Read hit in IDLE increments hit_count; read miss increments miss_count.
  - Both counters saturate at 16'hFFFF; writes are not counted.
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Shared package cache_pkg holds:
  - ADDR_W/DATA_W/LINES defaults and the MEMDELAY constant;
  - the state enum for IDLE/RESP/MREQ/MWAIT/WREQ;
  - tag/index width helpers and the line struct (valid, tag, data).
- Sub-module cache_line_array holds the valid/tag/data storage. It has a combinational read (hit, data) at a given index/tag, and a synchronous write port with fill and update modes plus an async invalidate-all on reset.
- cache_ctrl contains the FSM and the slowmem interface only.

Test Plan:
1. Cold read: after reset, read 0x0005 with slowmem m[5]=0x1234 -> one mem_strobe with rnotw=1, addr=0x0005; cpu_done about 7 cycles later with cpu_rdata=0x1234; valid[5]=1.
2. Repeat read of 0x0005 -> no mem_strobe; cpu_done at N+1 with 0x1234.
3. Conflict: read 0x000D (same index 5, tag 1) -> miss refills line 5. A following read of 0x0005 misses again.
4. Write hit then read: write 0x00AB to 0x000D -> mem_strobe with rnotw=0 and wdata=0x00AB, done at N+2. Read 0x000D -> hit returning 0x00AB. Write miss to 0x0020 -> line 0 remains invalid.
5. Busy drop and reset: cpu_req pulse during MWAIT is ignored, with exactly one done. Asserting reset during MWAIT -> IDLE, cpu_busy=0, late mem_mfc ignored, and the next read of 0x0005 misses.
6. With CACHE_STATS_EN, after scenarios 1–3: hit_count=1, miss_count=3.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped write-through cache controller.
// The optional hit/miss counters are enabled by defining CACHE_STATS_EN.
package cache_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned LINES_DEF  = 8;
  // Cycles slowmem takes from strobe to mfc.
  localparam int unsigned MEMDELAY   = 4;

  typedef enum logic [2:0] {
    StIdle,
    StResp,
    StMreq,
    StMwait,
    StWreq
  } state_e;

  function automatic int unsigned idx_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned lines);
    return addr_w - $clog2(lines);
  endfunction

  localparam int unsigned IDX_W_DEF = idx_w(LINES_DEF);
  localparam int unsigned TAG_W_DEF = tag_w(ADDR_W_DEF, LINES_DEF);

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_DEF-1:0] tag;
    logic [DATA_W_DEF-1:0] data;
  } line_t;

endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data storage for a direct-mapped cache: combinational lookup, synchronous
// fill (tag+data+valid) or update (data only), and asynchronous invalidate-all on reset.
module cache_line_array #(
  parameter int unsigned TagW  = 13,
  parameter int unsigned DataW = 16,
  parameter int unsigned Lines = 8,
  parameter int unsigned IdxW  = $clog2(Lines)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [IdxW-1:0]  rd_idx_i,
  input  logic [TagW-1:0]  rd_tag_i,
  output logic             rd_hit_o,
  output logic [DataW-1:0] rd_data_o,
  input  logic             wr_en_i,
  input  logic             wr_fill_i,
  input  logic [IdxW-1:0]  wr_idx_i,
  input  logic [TagW-1:0]  wr_tag_i,
  input  logic [DataW-1:0] wr_data_i
);

  logic [Lines-1:0] valid_q, valid_d;
  logic [TagW-1:0]  tag_q  [Lines];
  logic [DataW-1:0] data_q [Lines];

  assign rd_hit_o  = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_data_o = data_q[rd_idx_i];

  always_comb begin
    valid_d = valid_q;
    if (wr_en_i && wr_fill_i) valid_d[wr_idx_i] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) valid_q <= '0;
    else         valid_q <= valid_d;
  end

  // Tag/data need no reset; valid gates every use of them.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      data_q[wr_idx_i] <= wr_data_i;
      if (wr_fill_i) tag_q[wr_idx_i] <= wr_tag_i;
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-through cache controller: FSM plus slowmem strobe/rnotw/mfc interface.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LINES  = LINES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_rnotw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_busy,
  output logic              mem_strobe,
  output logic              mem_rnotw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_mfc,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  localparam int unsigned IDX_W = idx_w(LINES);
  localparam int unsigned TAG_W = tag_w(ADDR_W, LINES);

  state_e            state_q, state_d;
  logic              rnotw_q, rnotw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [ADDR_W-1:0] lk_addr;
  logic              lk_hit;
  logic [DATA_W-1:0] lk_data;
  logic              arr_we, arr_fill;
  logic [DATA_W-1:0] arr_wdata;

  // Look up the incoming address while idle, the captured one otherwise.
  assign lk_addr = (state_q == StIdle) ? cpu_addr : addr_q;

  cache_line_array #(
    .TagW  (TAG_W),
    .DataW (DATA_W),
    .Lines (LINES),
    .IdxW  (IDX_W)
  ) u_lines (
    .clk_i     (clk),
    .reset_i   (reset),
    .rd_idx_i  (lk_addr[IDX_W-1:0]),
    .rd_tag_i  (lk_addr[ADDR_W-1:IDX_W]),
    .rd_hit_o  (lk_hit),
    .rd_data_o (lk_data),
    .wr_en_i   (arr_we),
    .wr_fill_i (arr_fill),
    .wr_idx_i  (addr_q[IDX_W-1:0]),
    .wr_tag_i  (addr_q[ADDR_W-1:IDX_W]),
    .wr_data_i (arr_wdata)
  );

  always_comb begin
    state_d   = state_q;
    rnotw_d   = rnotw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    arr_we    = 1'b0;
    arr_fill  = 1'b0;
    arr_wdata = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          rnotw_d = cpu_rnotw;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          if (!cpu_rnotw) begin
            state_d = StWreq;
          end else if (lk_hit) begin
            rdata_d = lk_data;
            state_d = StResp;
          end else begin
            state_d = StMreq;
          end
        end
      end
      StMreq:  state_d = StMwait;
      StMwait: begin
        if (mem_mfc) begin
          arr_we    = 1'b1;
          arr_fill  = 1'b1;
          arr_wdata = mem_rdata;
          rdata_d   = mem_rdata;
          state_d   = StResp;
        end
      end
      StWreq: begin
        // Write-through, no allocate: only refresh data on a hit.
        arr_we  = lk_hit;
        state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      rnotw_q <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rnotw_q <= rnotw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign cpu_rdata  = rdata_q;
  assign cpu_done   = (state_q == StResp);
  assign cpu_busy   = (state_q != StIdle);
  assign mem_strobe = (state_q == StMreq) || (state_q == StWreq);
  assign mem_rnotw  = (state_q == StWreq) ? rnotw_q : 1'b1;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == StIdle && cpu_req && cpu_rnotw) begin
      if (lk_hit) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed self-checking bench for cache_ctrl with a behavioural slowmem (MEMDELAY latency).
module tb_cache_ctrl;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_rnotw = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_done, cpu_busy;
  logic        mem_strobe, mem_rnotw;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_mfc = 1'b0;
  logic [15:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_rnotw  (cpu_rnotw),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_done   (cpu_done),
    .cpu_busy   (cpu_busy),
    .mem_strobe (mem_strobe),
    .mem_rnotw  (mem_rnotw),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_mfc    (mem_mfc),
    .mem_rdata  (mem_rdata)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  // Slowmem model: preset contents plus a written-word overlay, mfc MEMDELAY edges after strobe.
  logic [15:0] wr_m [64];
  logic [63:0] wr_valid = '0;
  int          strobe_cnt = 0;
  logic        pending = 1'b0;
  int          dly = 0;
  logic [15:0] pend_addr = '0;
  logic [15:0] last_addr = '0;
  logic [15:0] last_wdata = '0;
  logic        last_rnotw = 1'b1;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    case (a)
      16'h0005: return 16'h1234;
      16'h000D: return 16'hBEEF;
      16'h0015: return 16'h7777;
      default:  return a ^ 16'hA5A5;
    endcase
  endfunction

  always @(posedge clk) begin
    mem_mfc <= 1'b0;
    if (mem_strobe) begin
      strobe_cnt <= strobe_cnt + 1;
      last_addr  <= mem_addr;
      last_rnotw <= mem_rnotw;
      last_wdata <= mem_wdata;
      if (!mem_rnotw) begin
        wr_m[mem_addr[5:0]]     <= mem_wdata;
        wr_valid[mem_addr[5:0]] <= 1'b1;
      end
      pend_addr <= mem_addr;
      dly       <= MEMDELAY;
      pending   <= 1'b1;
    end else if (pending) begin
      if (dly == 1) begin
        mem_mfc   <= 1'b1;
        mem_rdata <= wr_valid[pend_addr[5:0]] ? wr_m[pend_addr[5:0]] : init_val(pend_addr);
        pending   <= 1'b0;
      end else begin
        dly <= dly - 1;
      end
    end
  end

  task automatic wait_mem_idle();
    for (int i = 0; i < 20 && pending; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  // Issue one request; lat = cycles from the request cycle to cpu_done (0 on timeout).
  task automatic do_req(input logic rnotw, input logic [15:0] addr, input logic [15:0] wdata,
                        output int lat, output logic [15:0] rdata, output int strobes,
                        output logic done_after);
    int s0;
    wait_mem_idle();
    lat = 0;
    s0 = strobe_cnt;
    cpu_rnotw = rnotw; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (cpu_done) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    rdata = cpu_rdata;
    strobes = strobe_cnt - s0;
    @(posedge clk); #1;
    done_after = cpu_done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    total++; if (cpu_done !== 1'b0) $display("FAIL reset_done got %b want 0", cpu_done); else pass_cnt++;
    total++; if (cpu_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", cpu_busy); else pass_cnt++;
    total++; if (mem_strobe !== 1'b0) $display("FAIL reset_strobe got %b want 0", mem_strobe); else pass_cnt++;
    total++; if (mem_rnotw !== 1'b1) $display("FAIL reset_rnotw got %b want 1", mem_rnotw); else pass_cnt++;
    total++; if (cpu_rdata !== 16'h0) $display("FAIL reset_rdata got %h want 0000", cpu_rdata); else pass_cnt++;
    total++; if (mem_addr !== 16'h0) $display("FAIL reset_maddr got %h want 0000", mem_addr); else pass_cnt++;
    total++; if (mem_wdata !== 16'h0) $display("FAIL reset_mwdata got %h want 0000", mem_wdata); else pass_cnt++;
`ifdef CACHE_STATS_EN
    total++; if (hit_count !== 16'h0) $display("FAIL reset_hits got %0d want 0", hit_count); else pass_cnt++;
    total++; if (miss_count !== 16'h0) $display("FAIL reset_misses got %0d want 0", miss_count); else pass_cnt++;
`endif
  endtask

  task automatic test_cold_read();
    int lat, st; logic [15:0] rd; logic da;
    do_req(1'b1, 16'h0005, 16'h0, lat, rd, st, da);
    total++; if (lat != 7) $display("FAIL cold_latency got %0d want 7", lat); else pass_cnt++;
    total++; if (rd !== 16'h1234) $display("FAIL cold_rdata got %h want 1234", rd); else pass_cnt++;
    total++; if (st != 1) $display("FAIL cold_strobes got %0d want 1", st); else pass_cnt++;
    total++; if (last_addr !== 16'h0005 || last_rnotw !== 1'b1)
      $display("FAIL cold_mem_req got addr=%h rnotw=%b want 0005/1", last_addr, last_rnotw);
    else pass_cnt++;
    total++; if (da !== 1'b0) $display("FAIL cold_done_width got %b want 0", da); else pass_cnt++;
  endtask

  task automatic test_hit();
    int lat, st; logic [15:0] rd; logic da;
    do_req(1'b1, 16'h0005, 16'h0, lat, rd, st, da);
    total++; if (lat != 1) $display("FAIL hit_latency got %0d want 1", lat); else pass_cnt++;
    total++; if (rd !== 16'h1234) $display("FAIL hit_rdata got %h want 1234", rd); else pass_cnt++;
    total++; if (st != 0) $display("FAIL hit_strobes got %0d want 0", st); else pass_cnt++;
    total++; if (da !== 1'b0) $display("FAIL hit_done_width got %b want 0", da); else pass_cnt++;
  endtask

  task automatic test_conflict();
    int lat, st; logic [15:0] rd; logic da;
    do_req(1'b1, 16'h000D, 16'h0, lat, rd, st, da);
    total++; if (lat != 7 || rd !== 16'hBEEF)
      $display("FAIL conflict_fill got lat=%0d data=%h want 7/beef", lat, rd);
    else pass_cnt++;
    do_req(1'b1, 16'h0005, 16'h0, lat, rd, st, da);
    total++; if (lat != 7 || st != 1 || rd !== 16'h1234)
      $display("FAIL conflict_evict got lat=%0d strobes=%0d data=%h want 7/1/1234", lat, st, rd);
    else pass_cnt++;
`ifdef CACHE_STATS_EN
    total++; if (hit_count !== 16'd1) $display("FAIL stats_hits got %0d want 1", hit_count); else pass_cnt++;
    total++; if (miss_count !== 16'd3) $display("FAIL stats_misses got %0d want 3", miss_count); else pass_cnt++;
`endif
  endtask

  task automatic test_write();
    int lat, st; logic [15:0] rd; logic da;
    do_req(1'b1, 16'h000D, 16'h0, lat, rd, st, da);
    do_req(1'b0, 16'h000D, 16'h00AB, lat, rd, st, da);
    total++; if (lat != 2) $display("FAIL wr_hit_latency got %0d want 2", lat); else pass_cnt++;
    total++; if (st != 1 || last_rnotw !== 1'b0 || last_wdata !== 16'h00AB || last_addr !== 16'h000D)
      $display("FAIL wr_mem_req got n=%0d rnotw=%b wd=%h a=%h want 1/0/00ab/000d",
               st, last_rnotw, last_wdata, last_addr);
    else pass_cnt++;
    do_req(1'b1, 16'h000D, 16'h0, lat, rd, st, da);
    total++; if (lat != 1 || rd !== 16'h00AB)
      $display("FAIL wr_hit_readback got lat=%0d data=%h want 1/00ab", lat, rd);
    else pass_cnt++;
    do_req(1'b0, 16'h0020, 16'h5A5A, lat, rd, st, da);
    total++; if (lat != 2 || st != 1)
      $display("FAIL wr_miss got lat=%0d strobes=%0d want 2/1", lat, st);
    else pass_cnt++;
    do_req(1'b1, 16'h0020, 16'h0, lat, rd, st, da);
    total++; if (lat != 7 || rd !== 16'h5A5A)
      $display("FAIL wr_miss_no_alloc got lat=%0d data=%h want 7/5a5a", lat, rd);
    else pass_cnt++;
  endtask

  task automatic test_busy_drop();
    int dones = 0;
    int s0;
    logic busy_at_pulse = 1'b0;
    logic [15:0] rd = '0;
    wait_mem_idle();
    s0 = strobe_cnt;
    cpu_rnotw = 1'b1; cpu_addr = 16'h0015; cpu_req = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (cpu_done) begin
        dones++;
        rd = cpu_rdata;
      end
      if (i == 3) begin
        busy_at_pulse = cpu_busy;
        cpu_rnotw = 1'b0; cpu_addr = 16'h0030; cpu_wdata = 16'hDEAD; cpu_req = 1'b1;
      end
      if (i == 4) cpu_req = 1'b0;
      @(posedge clk); #1;
    end
    total++; if (busy_at_pulse !== 1'b1) $display("FAIL drop_busy got %b want 1", busy_at_pulse); else pass_cnt++;
    total++; if (dones != 1) $display("FAIL drop_dones got %0d want 1", dones); else pass_cnt++;
    total++; if (strobe_cnt - s0 != 1) $display("FAIL drop_strobes got %0d want 1", strobe_cnt - s0); else pass_cnt++;
    total++; if (rd !== 16'h7777) $display("FAIL drop_rdata got %h want 7777", rd); else pass_cnt++;
    total++; if (wr_valid[48] !== 1'b0) $display("FAIL drop_no_write got %b want 0", wr_valid[48]); else pass_cnt++;
  endtask

  task automatic test_reset_mid_miss();
    int lat, st, dones = 0;
    logic [15:0] rd; logic da;
    wait_mem_idle();
    cpu_rnotw = 1'b1; cpu_addr = 16'h0005; cpu_req = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    total++; if (cpu_busy !== 1'b0 || mem_strobe !== 1'b0)
      $display("FAIL midreset_idle got busy=%b strobe=%b want 0/0", cpu_busy, mem_strobe);
    else pass_cnt++;
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (cpu_done) dones++;
      @(posedge clk); #1;
    end
    total++; if (dones != 0 || pending !== 1'b0)
      $display("FAIL midreset_late_mfc got dones=%0d pending=%b want 0/0", dones, pending);
    else pass_cnt++;
    do_req(1'b1, 16'h0015, 16'h0, lat, rd, st, da);
    total++; if (lat != 7 || rd !== 16'h7777)
      $display("FAIL midreset_invalid got lat=%0d data=%h want 7/7777", lat, rd);
    else pass_cnt++;
    do_req(1'b1, 16'h0005, 16'h0, lat, rd, st, da);
    total++; if (lat != 7 || rd !== 16'h1234)
      $display("FAIL midreset_read5 got lat=%0d data=%h want 7/1234", lat, rd);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_hit();
    test_conflict();
    test_write();
    test_busy_drop();
    test_reset_mid_miss();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
